// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dct_pkg
//  Description : Shared ctl-field layout, lane-count range and helpers for the
//                round-robin lane distributor/collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package dct_pkg;

    // ctl nibble layout: {error[1:0], sop, eop}
    localparam int CTL_EOP    = 0;
    localparam int CTL_SOP    = 1;
    localparam int CTL_ERR_LO = 2;
    localparam int CTL_ERR_HI = 3;
    localparam int CTL_W      = 4;

    localparam int NLANES_MIN = 2;
    localparam int NLANES_MAX = 8;

    localparam int         FI_W   = 4;
    localparam logic [3:0] FI_MAX = 4'd15;

    typedef enum logic [0:0] {
        FR_IDLE = 1'b0,
        FR_BUSY = 1'b1
    } frame_st_e;

    function automatic int lane_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct_skid_slice.sv
`default_nettype none
// ============================================================================
//  Module      : dct_skid_slice
//  Description : Two-entry skid register slice; registered ready, 1 beat/cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dct_skid_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic         main_vld_q, main_vld_d;
    logic [W-1:0] main_dat_q, main_dat_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         rdy_q, rdy_d;
    logic         in_fire;

    assign in_fire = in_valid_i & rdy_q;

    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (!main_vld_q || out_ready_i) begin
            // ready is low while the skid entry is occupied, so no input can
            // arrive in the same cycle the skid entry drains into main
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_dat_d = skid_dat_q;
                skid_vld_d = 1'b0;
                skid_dat_d = '0;
            end else begin
                main_vld_d = in_fire;
                main_dat_d = in_fire ? in_data_i : '0;
            end
        end else if (in_fire) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_data_i;
        end
        rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            rdy_q      <= rdy_d;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_dat_q;

endmodule
`default_nettype wire

// File: rtl/dct_lane_rr.sv
`default_nettype none
// ============================================================================
//  Module      : dct_lane_rr
//  Description : Frame-granular round-robin dispatch to NLANES lanes and
//                in-order collection back onto a single stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module dct_lane_rr
    import dct_pkg::*;
#(
    parameter int NLANES = 2,
    parameter int W_IN   = 16,
    parameter int W_OUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sink_valid,
    input  logic                    sink_sop,
    input  logic                    sink_eop,
    output logic                    sink_ready,
    input  logic [1:0]              sink_error,
    input  logic [W_IN-1:0]         sink_real,
    input  logic [W_IN-1:0]         sink_imag,
    output logic [NLANES-1:0]       lane_sink_valid,
    input  logic [NLANES-1:0]       lane_sink_ready,
    output logic [4*NLANES-1:0]     lane_sink_ctl,
    output logic [W_IN*NLANES-1:0]  lane_sink_real,
    output logic [W_IN*NLANES-1:0]  lane_sink_imag,
    input  logic [NLANES-1:0]       lane_source_valid,
    output logic [NLANES-1:0]       lane_source_ready,
    input  logic [4*NLANES-1:0]     lane_source_ctl,
    input  logic [W_OUT*NLANES-1:0] lane_source_real,
    input  logic [W_OUT*NLANES-1:0] lane_source_imag,
    output logic                    source_valid,
    output logic                    source_sop,
    output logic                    source_eop,
    input  logic                    source_ready,
    output logic [1:0]              source_error,
    output logic [W_OUT-1:0]        source_real,
    output logic [W_OUT-1:0]        source_imag,
    output logic [3:0]              frames_inflight,
    output logic                    err_proto
);

    localparam int             LW        = lane_idx_w(NLANES);
    localparam int             PI_W      = CTL_W + 2 * W_IN;
    localparam int             PO_W      = CTL_W + 2 * W_OUT;
    localparam logic [LW-1:0]  LAST_LANE = LW'(NLANES - 1);

    logic [LW-1:0]   wr_lane_q, wr_lane_d;
    logic [LW-1:0]   rd_lane_q, rd_lane_d;
    logic [FI_W-1:0] fi_q, fi_d;
    logic            err_q, err_d;
    frame_st_e       frame_q, frame_d;

    logic [PI_W-1:0]  in_pld, disp_pld;
    logic             disp_valid, disp_ready, disp_fire, disp_eop;
    logic [CTL_W-1:0] disp_ctl;
    logic [PO_W-1:0]  coll_pld, src_pld;
    logic             coll_valid, coll_ready, coll_fire, coll_eop;
    logic             sink_fire;

    assign in_pld = {sink_error, sink_sop, sink_eop, sink_real, sink_imag};

    dct_skid_slice #(.W(PI_W)) u_in_slice (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (sink_valid),
        .in_data_i   (in_pld),
        .in_ready_o  (sink_ready),
        .out_valid_o (disp_valid),
        .out_data_o  (disp_pld),
        .out_ready_i (disp_ready)
    );

    assign disp_ctl   = disp_pld[2*W_IN +: CTL_W];
    assign disp_ready = lane_sink_ready[wr_lane_q];
    assign disp_fire  = disp_valid & disp_ready;
    assign disp_eop   = disp_fire & disp_ctl[CTL_EOP];

    assign coll_valid = lane_source_valid[rd_lane_q];
    assign coll_pld   = {lane_source_ctl[int'(rd_lane_q)*CTL_W +: CTL_W],
                         lane_source_real[int'(rd_lane_q)*W_OUT +: W_OUT],
                         lane_source_imag[int'(rd_lane_q)*W_OUT +: W_OUT]};
    assign coll_fire  = coll_valid & coll_ready;
    assign coll_eop   = coll_fire & coll_pld[2*W_OUT + CTL_EOP];

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        logic wr_sel, rd_sel;
        assign wr_sel = (wr_lane_q == LW'(i)) & disp_valid;
        assign rd_sel = (rd_lane_q == LW'(i));
        assign lane_sink_valid[i]                = wr_sel;
        assign lane_sink_ctl[i*CTL_W +: CTL_W]   = wr_sel ? disp_ctl : '0;
        assign lane_sink_real[i*W_IN +: W_IN]    = wr_sel ? disp_pld[W_IN +: W_IN] : '0;
        assign lane_sink_imag[i*W_IN +: W_IN]    = wr_sel ? disp_pld[0 +: W_IN] : '0;
        assign lane_source_ready[i]              = rd_sel & coll_ready;
    end

    dct_skid_slice #(.W(PO_W)) u_out_slice (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (coll_valid),
        .in_data_i   (coll_pld),
        .in_ready_o  (coll_ready),
        .out_valid_o (source_valid),
        .out_data_o  (src_pld),
        .out_ready_i (source_ready)
    );

    assign source_error = src_pld[2*W_OUT + CTL_ERR_LO +: 2];
    assign source_sop   = src_pld[2*W_OUT + CTL_SOP];
    assign source_eop   = src_pld[2*W_OUT + CTL_EOP];
    assign source_real  = src_pld[W_OUT +: W_OUT];
    assign source_imag  = src_pld[0 +: W_OUT];

    assign sink_fire = sink_valid & sink_ready;

    always_comb begin
        wr_lane_d = wr_lane_q;
        rd_lane_d = rd_lane_q;
        fi_d      = fi_q;
        err_d     = err_q;
        frame_d   = frame_q;

        if (disp_eop)
            wr_lane_d = (wr_lane_q == LAST_LANE) ? '0 : wr_lane_q + LW'(1);
        if (coll_eop)
            rd_lane_d = (rd_lane_q == LAST_LANE) ? '0 : rd_lane_q + LW'(1);

        if (disp_eop && !coll_eop && fi_q != FI_MAX)
            fi_d = fi_q + 4'd1;
        else if (coll_eop && !disp_eop && fi_q != '0)
            fi_d = fi_q - 4'd1;

        // framing is judged at the sink; offending beats still flow through
        if (sink_fire) begin
            if (sink_sop && frame_q == FR_BUSY)
                err_d = 1'b1;
            if (sink_eop && !sink_sop && frame_q == FR_IDLE)
                err_d = 1'b1;
            if (sink_eop)
                frame_d = FR_IDLE;
            else if (sink_sop)
                frame_d = FR_BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_lane_q <= '0;
            rd_lane_q <= '0;
            fi_q      <= '0;
            err_q     <= 1'b0;
            frame_q   <= FR_IDLE;
        end else begin
            wr_lane_q <= wr_lane_d;
            rd_lane_q <= rd_lane_d;
            fi_q      <= fi_d;
            err_q     <= err_d;
            frame_q   <= frame_d;
        end
    end

    assign frames_inflight = fi_q;
    assign err_proto       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dct_lane_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dct_lane_rr
//  Description : Randomised bench for dct_lane_rr with loop-back lane models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_lane_rr;

    localparam int NL = 3;
    localparam int WI = 16;
    localparam int WO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            sink_valid, sink_sop, sink_eop, sink_ready;
    logic [1:0]      sink_error;
    logic [WI-1:0]   sink_real, sink_imag;
    logic [NL-1:0]   lane_sink_valid, lane_sink_ready;
    logic [4*NL-1:0] lane_sink_ctl;
    logic [WI*NL-1:0] lane_sink_real, lane_sink_imag;
    logic [NL-1:0]   lane_source_valid, lane_source_ready;
    logic [4*NL-1:0] lane_source_ctl;
    logic [WO*NL-1:0] lane_source_real, lane_source_imag;
    logic            source_valid, source_sop, source_eop, source_ready;
    logic [1:0]      source_error;
    logic [WO-1:0]   source_real, source_imag;
    logic [3:0]      frames_inflight;
    logic            err_proto;

    dct_lane_rr #(.NLANES(NL), .W_IN(WI), .W_OUT(WO)) dut (
        .clk               (clk),
        .rst               (rst),
        .sink_valid        (sink_valid),
        .sink_sop          (sink_sop),
        .sink_eop          (sink_eop),
        .sink_ready        (sink_ready),
        .sink_error        (sink_error),
        .sink_real         (sink_real),
        .sink_imag         (sink_imag),
        .lane_sink_valid   (lane_sink_valid),
        .lane_sink_ready   (lane_sink_ready),
        .lane_sink_ctl     (lane_sink_ctl),
        .lane_sink_real    (lane_sink_real),
        .lane_sink_imag    (lane_sink_imag),
        .lane_source_valid (lane_source_valid),
        .lane_source_ready (lane_source_ready),
        .lane_source_ctl   (lane_source_ctl),
        .lane_source_real  (lane_source_real),
        .lane_source_imag  (lane_source_imag),
        .source_valid      (source_valid),
        .source_sop        (source_sop),
        .source_eop        (source_eop),
        .source_ready      (source_ready),
        .source_error      (source_error),
        .source_real       (source_real),
        .source_imag       (source_imag),
        .frames_inflight   (frames_inflight),
        .err_proto         (err_proto)
    );

    typedef struct packed {
        logic [1:0]  err;
        logic        sop;
        logic        eop;
        logic [15:0] re;
        logic [15:0] im;
    } beat_t;

    beat_t tx_q[$];
    beat_t disp_q[$];
    int    disp_lane_q[$];
    int    disp_cyc_q[$];
    beat_t exp_q[$];
    beat_t lane_q[NL][$];

    bit hold[NL];
    int lane_rdy_pct = 100;
    int gap_pct      = 0;
    int src_mode     = 0;
    bit src_tog      = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: frames go to lane (frame number mod NL) and come back in order
    int m_sink_eops, m_disp_eops, m_coll_eops, m_fi;
    bit m_in_frame, m_err;
    int lane_beats[NL];
    bit lat_chk;
    int low_run, max_low;
    bit both_seen;
    int first_lane;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        tx_q.delete(); disp_q.delete(); disp_lane_q.delete(); disp_cyc_q.delete(); exp_q.delete();
        for (int i = 0; i < NL; i++) begin
            lane_q[i].delete();
            hold[i]       = 1'b0;
            lane_beats[i] = 0;
        end
        m_sink_eops = 0; m_disp_eops = 0; m_coll_eops = 0; m_fi = 0;
        m_in_frame  = 1'b0; m_err = 1'b0;
        low_run = 0; max_low = 0; first_lane = -1;
    endtask

    task automatic drive();
        beat_t b;
        sink_valid = (tx_q.size() > 0) && ($urandom_range(99) >= gap_pct);
        b = sink_valid ? tx_q[0] : '0;
        {sink_error, sink_sop, sink_eop, sink_real, sink_imag} = b;
        for (int i = 0; i < NL; i++) begin
            lane_sink_ready[i]   = ($urandom_range(99) < lane_rdy_pct);
            lane_source_valid[i] = (lane_q[i].size() > 0) && !hold[i];
            b = lane_source_valid[i] ? lane_q[i][0] : '0;
            lane_source_ctl[4*i +: 4]    = {b.err, b.sop, b.eop};
            lane_source_real[WO*i +: WO] = b.re;
            lane_source_imag[WO*i +: WO] = b.im;
        end
        src_tog = ~src_tog;
        case (src_mode)
            1:       source_ready = src_tog;
            2:       source_ready = ($urandom_range(3) != 0);
            default: source_ready = 1'b1;
        endcase
    endtask

    task automatic step();
        beat_t b, eb;
        logic [NL-1:0] wmask, rmask;
        logic anyidle;
        bit ev_d, ev_c;
        int el, ec;
        @(negedge clk);
        cyc++;
        ev_d = 1'b0; ev_c = 1'b0;
        wmask = NL'(1) << (m_disp_eops % NL);
        rmask = NL'(1) << (m_coll_eops % NL);
        chk("frames_inflight", frames_inflight, m_fi);
        chk("err_proto", err_proto, m_err);
        chk("lane_sink_valid_onehot", lane_sink_valid & ~wmask, 0);
        chk("lane_source_ready_onehot", lane_source_ready & ~rmask, 0);
        anyidle = 1'b0;
        for (int i = 0; i < NL; i++)
            if (!wmask[i])
                anyidle |= |{lane_sink_ctl[4*i +: 4], lane_sink_real[WI*i +: WI], lane_sink_imag[WI*i +: WI]};
        chk("idle_lane_payload", anyidle, 0);
        if (!sink_ready) low_run++; else low_run = 0;
        if (low_run > max_low) max_low = low_run;

        if (sink_valid && sink_ready) begin
            b = tx_q.pop_front();
            disp_q.push_back(b);
            disp_lane_q.push_back(m_sink_eops % NL);
            disp_cyc_q.push_back(cyc);
            exp_q.push_back(b);
            if (b.sop && m_in_frame) m_err = 1'b1;
            if (b.eop && !b.sop && !m_in_frame) m_err = 1'b1;
            if (b.eop) m_in_frame = 1'b0;
            else if (b.sop) m_in_frame = 1'b1;
            if (b.eop) m_sink_eops++;
        end

        for (int i = 0; i < NL; i++) begin
            if (lane_sink_valid[i] && lane_sink_ready[i]) begin
                b = beat_t'({lane_sink_ctl[4*i +: 4], lane_sink_real[WI*i +: WI], lane_sink_imag[WI*i +: WI]});
                if (disp_q.size() == 0) begin
                    chk("dispatch_spurious", 1, 0);
                end else begin
                    eb = disp_q.pop_front();
                    el = disp_lane_q.pop_front();
                    ec = disp_cyc_q.pop_front();
                    chk("dispatch_data", b, eb);
                    chk("dispatch_lane", i, el);
                    if (lat_chk) chk("sink_to_lane_latency", cyc - ec, 1);
                end
                lane_q[i].push_back(b);
                lane_beats[i]++;
                if (first_lane < 0) first_lane = i;
                if (b.eop) ev_d = 1'b1;
            end
        end

        for (int i = 0; i < NL; i++) begin
            if (lane_source_valid[i] && lane_source_ready[i]) begin
                b = lane_q[i].pop_front();
                if (b.eop) ev_c = 1'b1;
            end
        end

        if (source_valid && source_ready) begin
            b = beat_t'({source_error, source_sop, source_eop, source_real, source_imag});
            if (exp_q.size() == 0) chk("source_spurious", 1, 0);
            else chk("source_data", b, exp_q.pop_front());
        end

        if (ev_d && !ev_c) m_fi = (m_fi < 15) ? m_fi + 1 : 15;
        else if (ev_c && !ev_d) m_fi = (m_fi > 0) ? m_fi - 1 : 0;
        if (ev_d) m_disp_eops++;
        if (ev_c) m_coll_eops++;
        if (ev_d && ev_c) both_seen = 1'b1;

        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("reset_outputs_zero",
            |{sink_ready, lane_sink_valid, lane_sink_ctl, lane_sink_real, lane_sink_imag,
              lane_source_ready, source_valid, source_sop, source_eop, source_error,
              source_real, source_imag}, 0);
        chk("reset_frames_inflight", frames_inflight, 0);
        chk("reset_err_proto", err_proto, 0);
        clear_model();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("sink_ready_before_first_edge", sink_ready, 0);
        @(posedge clk);
        #1;
        chk("sink_ready_after_first_edge", sink_ready, 1);
        drive();
    endtask

    task automatic send_frame(input int len, input int extra_sop = -1);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.re  = 16'($urandom);
            b.im  = 16'($urandom);
            b.err = 2'($urandom_range(3));
            b.sop = (k == 0) || (k == extra_sop);
            b.eop = (k == len - 1);
            tx_q.push_back(b);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((tx_q.size() > 0 || exp_q.size() > 0) && k < 3000) begin
            step();
            k++;
        end
        chk("drain_within_budget", k < 3000, 1);
        step();
        chk("frames_inflight_drained", frames_inflight, 0);
    endtask

    initial begin
        int k;
        clear_model();
        drive();
        do_reset();

        // four back-to-back 8-beat frames over three lanes
        lat_chk = 1'b1;
        repeat (4) send_frame(8);
        drive();
        drain();
        lat_chk = 1'b0;
        chk("lane0_beats", lane_beats[0], 16);
        chk("lane1_beats", lane_beats[1], 8);
        chk("lane2_beats", lane_beats[2], 8);

        // lane 1 finishes first but must wait for lane 0
        do_reset();
        hold[0] = 1'b1;
        send_frame(6);
        send_frame(6);
        drive();
        repeat (30) begin
            step();
            chk("lane1_held", lane_source_ready[1], 0);
            chk("source_idle_while_held", source_valid, 0);
        end
        chk("lane1_frame_waiting", lane_q[1].size(), 6);
        hold[0] = 1'b0;
        drain();

        // source_ready toggling every cycle
        src_mode = 1;
        max_low  = 0;
        send_frame(16);
        send_frame(16);
        drive();
        drain();
        chk("sink_ready_low_run", max_low <= 2, 1);
        src_mode = 0;

        // dispatch eop and collect eop in the same cycle at two in flight
        do_reset();
        hold[0] = 1'b1;
        send_frame(4);
        send_frame(4);
        drive();
        repeat (15) step();
        chk("inflight_two", frames_inflight, 2);
        both_seen = 1'b0;
        send_frame(4);
        drive();
        step();
        hold[0] = 1'b0;
        drive();
        repeat (10) step();
        chk("coincident_eops_seen", both_seen, 1);
        drain();

        // sop on beat 3 sets a sticky framing error
        send_frame(8, 2);
        send_frame(5);
        drive();
        drain();
        chk("err_proto_set", err_proto, 1);
        send_frame(3);
        drive();
        drain();
        chk("err_proto_sticky", err_proto, 1);

        // reset on beat 5 of the frame in lane 1
        do_reset();
        send_frame(8);
        send_frame(8);
        drive();
        k = 0;
        while (lane_beats[1] < 5 && k < 200) begin
            step();
            k++;
        end
        chk("reached_lane1_beat5", lane_beats[1], 5);
        do_reset();
        send_frame(8);
        drive();
        k = 0;
        while (first_lane < 0 && k < 50) begin
            step();
            k++;
        end
        chk("first_frame_after_reset_lane", first_lane, 0);
        drain();

        // randomised traffic with lane and source backpressure
        lane_rdy_pct = 70;
        gap_pct      = 20;
        src_mode     = 2;
        for (int f = 0; f < 40; f++) send_frame($urandom_range(1, 10));
        drive();
        repeat (600) begin
            if ($urandom_range(7) == 0) begin
                k = $urandom_range(NL - 1);
                hold[k] = ~hold[k];
            end
            step();
        end
        for (int i = 0; i < NL; i++) hold[i] = 1'b0;
        drain();
        lane_rdy_pct = 100;
        gap_pct      = 0;
        src_mode     = 0;

        // frames_inflight saturation
        do_reset();
        for (int i = 0; i < NL; i++) hold[i] = 1'b1;
        repeat (16) send_frame(1);
        drive();
        repeat (40) step();
        chk("inflight_saturated", frames_inflight, 15);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dct_lane_rr.md
DCT_LANE_RR -- requirements
Module: dct_lane_rr

Interface
REQ-001 SHALL have parameter NLANES, default 2, number of downstream processing lanes (legal range 2..8).
REQ-002 SHALL have parameter W_IN, default 16, sample width of each real/imag component toward the lanes.
REQ-003 SHALL have parameter W_OUT, default 16, sample width of each real/imag component returned by the lanes.
REQ-004 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports sink_valid/sink_sop/sink_eop  in  1 each  upstream beat qualifiers.
REQ-007 SHALL have port sink_ready  out  1  upstream backpressure.
REQ-008 SHALL have ports sink_error  in  2, and sink_real/sink_imag  in  W_IN  upstream payload.
REQ-009 SHALL have ports lane_sink_valid  out  NLANES, lane_sink_ready  in  NLANES  per-lane handshake.
REQ-010 SHALL have ports lane_sink_ctl  out  4*NLANES  {error[1:0],sop,eop} per lane, and lane_sink_real/imag  out  W_IN*NLANES.
REQ-011 SHALL have ports lane_source_valid  in  NLANES, lane_source_ready  out  NLANES, lane_source_ctl  in  4*NLANES, and lane_source_real/imag  in  W_OUT*NLANES.
REQ-012 SHALL have ports source_valid/sop/eop  out  1, source_ready  in  1, source_error  out  2, and source_real/imag  out  W_OUT.
REQ-013 SHALL have port frames_inflight  out  4  frames dispatched but not yet fully collected.
REQ-014 SHALL have port err_proto  out  1  sticky sop/eop framing violation flag.

Function
REQ-015 Input stage SHALL be a 2-entry skid slice: sink_ready is registered and equals "skid entry empty"; full throughput of 1 beat/cycle.
REQ-016 Dispatch pointer wr_lane (reset 0) SHALL route each slice-output beat only to lane wr_lane; all other lanes SHALL have valid=0 and payload 0.
REQ-017 wr_lane SHALL advance modulo NLANES on the cycle a beat with eop is accepted by lane wr_lane (valid and ready both high).
REQ-018 Latency sink acceptance -> lane_sink_valid SHALL be exactly 1 cycle when no backpressure is present.
REQ-019 Collect pointer rd_lane (reset 0) SHALL drive lane_source_ready high only for lane rd_lane, gated by output slice space; all others 0.
REQ-020 rd_lane SHALL advance modulo NLANES when an eop beat from lane rd_lane is accepted; frames leave in dispatch order.
REQ-021 Output stage SHALL be a 2-entry skid slice; lane -> source latency is 1 cycle; source_valid is never withdrawn without source_ready.
REQ-022 frames_inflight SHALL +1 on each dispatched eop and -1 on each collected eop; when both occur in the same cycle it SHALL remain unchanged; it saturates at 15.
REQ-023 A sop accepted while mid-frame, or an eop accepted while not in a frame (a single-beat sop+eop frame is legal), SHALL set err_proto; the beat is still forwarded and the pointer rules still apply.
REQ-024 err_proto SHALL clear only on reset.

Reset
REQ-025 rst SHALL asynchronously clear: pointers to 0, both skid slices empty, sink_ready 0, all valid outputs 0, payload outputs 0, frames_inflight 0, err_proto 0.
REQ-026 sink_ready SHALL rise on the first clk edge after rst deasserts.
REQ-027 A reset asserted mid-frame SHALL discard all partial frames; the next accepted beat is treated as outside a frame.

Structure
REQ-028 Package dct_pkg SHALL hold the ctl bit positions (EOP=0, SOP=1, ERR=3:2), the NLANES legal range, and the lane-index width function.
REQ-029 Sub-module dct_skid_slice (parametrised payload width) SHALL be instantiated once for the input stage and once for the output stage.

Verification
REQ-030 NLANES=3 with three back-to-back 8-beat frames -> lanes 0,1,2 each receive exactly 8 beats; the 4th frame goes to lane 0.
REQ-031 Lane 1 returns its frame before lane 0 -> source emits lane 0's frame first; lane 1 is held with ready=0 until lane 0's eop.
REQ-032 source_ready toggling 1,0 every cycle over a 16-beat frame -> no beat lost or duplicated and order preserved; sink_ready is never low for more than 2 cycles consecutively.
REQ-033 Dispatch eop and collect eop in the same cycle with frames_inflight=2 -> value stays 2.
REQ-034 sop asserted on beat 3 of a frame -> err_proto=1 and stays 1 until rst.
REQ-035 rst pulsed on beat 5 of a frame in lane 1 -> all outputs 0 asynchronously; the next frame goes to lane 0.
